// File: rtl/rx_rr_arbiter.sv
// Round-robin receive arbiter: picks one of five two-phase req/ack senders per
// cycle and writes its flit into the router input FIFO, honouring fifo_full.
`ifndef SIZE
`define SIZE 8
`endif

module rx_rr_arbiter #(
  parameter int id   = -1,
  parameter int SIZE = `SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        fifo_push_req,
  input  logic [SIZE*5-1:0] fifo_push_data,
  output logic [4:0]        fifo_push_ack,
  output logic              fifo_write,
  output logic [SIZE-1:0]   fifo_data_in,
  input  logic              fifo_full,
  output logic [2:0]        grant_idx,
  output logic [2:0]        dbg_ptr_o,
  output logic [4:0]        dbg_pend_o
);

  // Handshake: pend[k] = req[k] ^ ack[k]. A grant toggles ack[k]; the sender may
  // only toggle req[k] again once it has seen that ack toggle.

  localparam logic [2:0] IDLE_IDX = 3'd7;

  // id only tags the instance; values below -1 are reserved and ignored.
  if (id < -1) begin : g_reserved_id
  end

  logic [4:0]      ack_q,   ack_d;
  logic            write_q, write_d;
  logic [SIZE-1:0] data_q,  data_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      ptr_q,   ptr_d;

  logic [4:0]      pend;
  logic            any_pend;
  logic            grant_en;
  logic [2:0]      sel;
  logic [4:0]      sel_oh;
  logic [SIZE-1:0] sel_data;
  logic            found;
  logic [3:0]      cand;

  assign pend     = fifo_push_req ^ ack_q;
  assign any_pend = |pend;
  assign grant_en = any_pend && !fifo_full;

  // Circular search starting at ptr; cand is kept in 0..4 by a single wrap.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    cand  = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!found && pend[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
  end

  assign sel_oh = 5'b00001 << sel;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < 5; k++) begin
      if (sel == 3'(k)) sel_data = fifo_push_data[k*SIZE +: SIZE];
    end
  end

  always_comb begin
    ack_d   = ack_q;
    write_d = 1'b0;
    data_d  = data_q;
    grant_d = IDLE_IDX;
    ptr_d   = ptr_q;
    if (grant_en) begin
      ack_d   = ack_q ^ sel_oh;
      write_d = 1'b1;
      data_d  = sel_data;
      grant_d = sel;
      ptr_d   = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      grant_q <= IDLE_IDX;
      ptr_q   <= 3'd0;
    end else begin
      ack_q   <= ack_d;
      write_q <= write_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign fifo_push_ack = ack_q;
  assign fifo_write    = write_q;
  assign fifo_data_in  = data_q;
  assign grant_idx     = grant_q;
  assign dbg_ptr_o     = ptr_q;
  assign dbg_pend_o    = pend;

  ptr_range_a: assert property (@(posedge clk) disable iff (reset) ptr_q <= 3'd4);
  idle_idx_a: assert property (@(posedge clk) disable iff (reset)
                               fifo_write || (grant_idx == IDLE_IDX));

endmodule

// File: tb/tb_rx_rr_arbiter.sv
// Bench for rx_rr_arbiter: vector table, hand-written corner sequences and a
// randomized run against a toggle-counting reference model with a flit queue.
module tb_rx_rr_arbiter;

  localparam int SIZE = 8;
  localparam int W    = 3 + SIZE;

  logic              clk;
  logic              reset;
  logic [4:0]        fifo_push_req;
  logic [SIZE*5-1:0] fifo_push_data;
  logic [4:0]        fifo_push_ack;
  logic              fifo_write;
  logic [SIZE-1:0]   fifo_data_in;
  logic              fifo_full;
  logic [2:0]        grant_idx;
  logic [2:0]        dbg_ptr_o;
  logic [4:0]        dbg_pend_o;

  rx_rr_arbiter #(.id(3), .SIZE(SIZE)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_push_req  (fifo_push_req),
    .fifo_push_data (fifo_push_data),
    .fifo_push_ack  (fifo_push_ack),
    .fifo_write     (fifo_write),
    .fifo_data_in   (fifo_data_in),
    .fifo_full      (fifo_full),
    .grant_idx      (grant_idx),
    .dbg_ptr_o      (dbg_ptr_o),
    .dbg_pend_o     (dbg_pend_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected {grant_idx, flit} in grant order.
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]        req;
    logic [SIZE*5-1:0] data;
    logic              full;
    logic              exp_w;
    logic [SIZE-1:0]   exp_d;
    logic [2:0]        exp_g;
    logic [4:0]        exp_ack;
    logic [2:0]        exp_ptr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fifo_push_req  = '0;
    fifo_push_data = '0;
    fifo_full      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [4:0] ack_exp);
    chk({tag, "_write"}, 64'(fifo_write), 64'd0);
    chk({tag, "_grant"}, 64'(grant_idx), 64'd7);
    chk({tag, "_ack"},   64'(fifo_push_ack), 64'(ack_exp));
  endtask

  // Reference model state: per-sender toggle counts, pointer, held flit.
  int              req_cnt[5];
  int              ack_cnt[5];
  int              m_ptr;
  logic [SIZE-1:0] m_data;
  int              wait_cnt[5];
  int              max_wait;

  initial begin
    logic [63:0]     r;
    logic [4:0]      pend_before;
    logic [4:0]      e_ack;
    logic [W-1:0]    got;
    logic [W-1:0]    want;
    logic            e_w;
    logic [2:0]      e_g;
    int              sel;
    int              k;

    // Vector table, applied back to back from reset (ptr starts at 0).
    vecs[0]  = '{5'b00000, 40'h00_00_00_00_00, 1'b0, 1'b0, 8'h00, 3'd7, 5'b00000, 3'd0};
    vecs[1]  = '{5'b00100, 40'h00_00_A5_00_00, 1'b0, 1'b1, 8'hA5, 3'd2, 5'b00100, 3'd3};
    vecs[2]  = '{5'b00100, 40'h00_00_A5_00_00, 1'b0, 1'b0, 8'hA5, 3'd7, 5'b00100, 3'd3};
    vecs[3]  = '{5'b10110, 40'hC4_00_00_C1_00, 1'b0, 1'b1, 8'hC4, 3'd4, 5'b10100, 3'd0};
    vecs[4]  = '{5'b10110, 40'hC4_00_00_C1_00, 1'b0, 1'b1, 8'hC1, 3'd1, 5'b10110, 3'd2};
    for (int i = 5; i <= 10; i++)
      vecs[i] = '{5'b11111, 40'h00_B3_00_00_B0, 1'b1, 1'b0, 8'hC1, 3'd7, 5'b10110, 3'd2};
    vecs[11] = '{5'b11111, 40'h00_B3_00_00_B0, 1'b0, 1'b1, 8'hB3, 3'd3, 5'b11110, 3'd4};
    vecs[12] = '{5'b11111, 40'h00_B3_00_00_B0, 1'b0, 1'b1, 8'hB0, 3'd0, 5'b11111, 3'd1};
    vecs[13] = '{5'b11111, 40'h00_B3_00_00_B0, 1'b0, 1'b0, 8'hB0, 3'd7, 5'b11111, 3'd1};

    // Reset values and idle
    do_reset();
    chk_idle_outputs("reset", 5'b00000);
    chk("reset_data", 64'(fifo_data_in), 64'd0);
    chk("reset_ptr",  64'(dbg_ptr_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle_outputs("idle", 5'b00000);
    end

    // Table: single sender, rotation, backpressure
    for (int i = 0; i < 14; i++) begin
      fifo_push_req  = vecs[i].req;
      fifo_push_data = vecs[i].data;
      fifo_full      = vecs[i].full;
      tick();
      chk($sformatf("vec%0d_write", i), 64'(fifo_write),    64'(vecs[i].exp_w));
      chk($sformatf("vec%0d_data",  i), 64'(fifo_data_in),  64'(vecs[i].exp_d));
      chk($sformatf("vec%0d_grant", i), 64'(grant_idx),     64'(vecs[i].exp_g));
      chk($sformatf("vec%0d_ack",   i), 64'(fifo_push_ack), 64'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_ptr",   i), 64'(dbg_ptr_o),     64'(vecs[i].exp_ptr));
    end

    // All five toggle together from reset
    do_reset();
    fifo_push_data = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    fifo_push_req  = 5'b11111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("burst%0d_write", g), 64'(fifo_write),   64'd1);
      chk($sformatf("burst%0d_grant", g), 64'(grant_idx),    64'(g));
      chk($sformatf("burst%0d_data",  g), 64'(fifo_data_in), 64'(8'h10 + g));
    end
    chk("burst_ack", 64'(fifo_push_ack), 64'h1f);
    tick();
    chk("burst_end_write", 64'(fifo_write), 64'd0);
    chk("burst_end_ptr",   64'(dbg_ptr_o),  64'd0);

    // Reset during the 3rd of 5 grants
    do_reset();
    fifo_push_data = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
    fifo_push_req  = 5'b11111;
    repeat (3) tick();
    chk("midrst_pre_write", 64'(fifo_write), 64'd1);
    chk("midrst_pre_grant", 64'(grant_idx),  64'd2);
    #2;
    reset         = 1'b1;
    fifo_push_req = '0;
    #1;
    chk_idle_outputs("midrst_async", 5'b00000);
    chk("midrst_async_data", 64'(fifo_data_in), 64'd0);
    tick();
    reset = 1'b0;
    chk("midrst_ptr", 64'(dbg_ptr_o), 64'd0);
    tick();
    chk_idle_outputs("midrst_after", 5'b00000);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_cnt[i]  = 0;
      ack_cnt[i]  = 0;
      wait_cnt[i] = 0;
    end
    m_ptr    = 0;
    m_data   = '0;
    max_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < 5; s++) begin
        if (req_cnt[s] == ack_cnt[s] && $urandom_range(0, 99) < 35) begin
          fifo_push_req[s] = ~fifo_push_req[s];
          req_cnt[s]++;
        end
      end
      r              = {$urandom, $urandom};
      fifo_push_data = r[SIZE*5-1:0];
      fifo_full      = ($urandom_range(0, 3) == 0);

      pend_before = '0;
      for (int s = 0; s < 5; s++) pend_before[s] = (req_cnt[s] > ack_cnt[s]);

      sel = -1;
      if (!fifo_full) begin
        for (int i = 0; i < 5; i++) begin
          k = (m_ptr + i) % 5;
          if (sel < 0 && req_cnt[k] > ack_cnt[k]) sel = k;
        end
      end
      e_w = 1'b0;
      e_g = 3'd7;
      if (sel >= 0) begin
        ack_cnt[sel]++;
        m_data = fifo_push_data[sel*SIZE +: SIZE];
        m_ptr  = (sel + 1) % 5;
        e_w    = 1'b1;
        e_g    = 3'(sel);
        exp_q.push_back({e_g, m_data});
      end
      for (int s = 0; s < 5; s++) e_ack[s] = ((ack_cnt[s] % 2) == 1);

      tick();
      chk("rand_write", 64'(fifo_write),    64'(e_w));
      chk("rand_grant", 64'(grant_idx),     64'(e_g));
      chk("rand_ack",   64'(fifo_push_ack), 64'(e_ack));
      chk("rand_data",  64'(fifo_data_in),  64'(m_data));
      chk("rand_ptr",   64'(dbg_ptr_o),     64'(m_ptr));

      if (fifo_write) begin
        got = {grant_idx, fifo_data_in};
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_flit", 64'(got), 64'h7ff);
        end else begin
          want = exp_q.pop_front();
          chk("sb_flit", 64'(got), 64'(want));
        end
        // Fairness measured on observed grants
        for (int s = 0; s < 5; s++) begin
          if (pend_before[s] && (32'(grant_idx) != s)) begin
            wait_cnt[s]++;
            if (wait_cnt[s] > max_wait) max_wait = wait_cnt[s];
          end
        end
        if (grant_idx <= 3'd4) wait_cnt[grant_idx] = 0;
      end
    end
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    chk("fair_within_4", 64'(max_wait <= 4), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
